// File: rtl/packet_tx.sv
// packet_tx: reads a packet back from data SRAM and streams it on a
// valid/ready 32-bit interface with last/keep framing, verifying the
// IPv4 header checksum on the way through.
module packet_tx #(
  parameter int AW       = 10,
  parameter int HDR_BYTE = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [15:0]   pkt_len,
  output logic          busy,
  output logic          sram_ce,
  output logic [AW-1:0] sram_addr,
  input  logic [31:0]   sram_rdata,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [31:0]   tx_data,
  output logic [3:0]    tx_keep,
  output logic          tx_last,
  output logic          done,
  output logic          csum_ok
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FIN    = 2'd2
  } state_t;

  // Header window: word CS_FIRST contributes only its low halfword and
  // word CS_LAST only its high halfword (header starts mid-word).
  localparam logic [15:0] CS_FIRST   = 16'(HDR_BYTE / 4);
  localparam logic [15:0] CS_LAST    = 16'((HDR_BYTE + 20) / 4);
  localparam logic [15:0] CS_MIN_LEN = 16'(HDR_BYTE + 20);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   nwords_q, nwords_d;
  logic [15:0]   issued_q, issued_d;
  logic [15:0]   wr_idx_q, wr_idx_d;
  logic [15:0]   beat_q, beat_d;
  logic          inflight_q, inflight_d;
  logic [1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [31:0]   head_q, head_d;
  logic [31:0]   tail_q, tail_d;
  logic [15:0]   acc_q, acc_d;
  logic          csum_ok_q, csum_ok_d;

  logic          pop;
  logic          push;
  logic          rd_en;
  logic [2:0]    occ;
  logic          last_beat;

  // One's-complement add with end-around carry.
  function automatic logic [15:0] add1c(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'b0, s[16]};
  endfunction

  assign tx_valid  = (fifo_cnt_q != 2'd0);
  assign tx_data   = head_q;
  assign pop       = tx_valid & tx_ready;
  assign push      = inflight_q;
  assign last_beat = (beat_q == nwords_q - 16'd1);
  assign tx_last   = tx_valid & last_beat;
  assign occ       = {1'b0, fifo_cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign rd_en     = (state_q == STREAM) && (issued_q < nwords_q) && (occ < 3'd2);
  assign sram_ce   = rd_en;
  assign sram_addr = addr_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign csum_ok   = csum_ok_q;

  // Byte enables: full on every beat except a short final one.
  always_comb begin
    tx_keep = '0;
    if (tx_valid) begin
      if (!last_beat) begin
        tx_keep = 4'b1111;
      end else begin
        case (len_q[1:0])
          2'd0:    tx_keep = 4'b1111;
          2'd1:    tx_keep = 4'b1000;
          2'd2:    tx_keep = 4'b1100;
          default: tx_keep = 4'b1110;
        endcase
      end
    end
  end

  // Next-state: FSM, read issue, FIFO, checksum accumulation.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    nwords_d   = nwords_q;
    issued_d   = issued_q;
    wr_idx_d   = wr_idx_q;
    beat_d     = beat_q;
    inflight_d = rd_en;
    fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    head_d     = head_q;
    tail_d     = tail_q;
    acc_d      = acc_q;
    csum_ok_d  = csum_ok_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d     = pkt_len;
          addr_d    = base_addr;
          nwords_d  = {2'b0, pkt_len[15:2]} + {15'b0, |pkt_len[1:0]};
          issued_d  = '0;
          wr_idx_d  = '0;
          beat_d    = '0;
          acc_d     = '0;
          csum_ok_d = 1'b0;
          state_d   = (pkt_len == 16'd0) ? FIN : STREAM;
        end
      end
      STREAM: begin
        if (pop && last_beat) begin
          state_d   = FIN;
          csum_ok_d = (len_q >= CS_MIN_LEN) && (acc_q == 16'hFFFF);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rd_en) begin
      addr_d   = addr_q + 1'b1;
      issued_d = issued_q + 16'd1;
    end

    if (pop) begin
      beat_d = beat_q + 16'd1;
    end

    // Head is always the output word; tail only fills when head is occupied.
    case ({push, pop})
      2'b10: begin
        if (fifo_cnt_q == 2'd0) head_d = sram_rdata;
        else                    tail_d = sram_rdata;
      end
      2'b01: begin
        head_d = tail_q;
      end
      2'b11: begin
        if (fifo_cnt_q == 2'd1) begin
          head_d = sram_rdata;
        end else begin
          head_d = tail_q;
          tail_d = sram_rdata;
        end
      end
      default: ;
    endcase

    if (push) begin
      wr_idx_d = wr_idx_q + 16'd1;
      if (wr_idx_q == CS_FIRST) begin
        acc_d = add1c(acc_q, sram_rdata[15:0]);
      end else if ((wr_idx_q > CS_FIRST) && (wr_idx_q < CS_LAST)) begin
        acc_d = add1c(add1c(acc_q, sram_rdata[31:16]), sram_rdata[15:0]);
      end else if (wr_idx_q == CS_LAST) begin
        acc_d = add1c(acc_q, sram_rdata[31:16]);
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      nwords_q   <= '0;
      issued_q   <= '0;
      wr_idx_q   <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      fifo_cnt_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      acc_q      <= '0;
      csum_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      nwords_q   <= nwords_d;
      issued_q   <= issued_d;
      wr_idx_q   <= wr_idx_d;
      beat_q     <= beat_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      acc_q      <= acc_d;
      csum_ok_q  <= csum_ok_d;
    end
  end

endmodule

// File: tb/tb_packet_tx.sv
// Scoreboard bench for packet_tx: stimulus pushes expected beats, read
// addresses and checksum verdicts; a negedge monitor pops and compares.
module tb_packet_tx;

  localparam int AW = 10;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [15:0]   pkt_len;
  logic          busy;
  logic          sram_ce;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_rdata = '0;
  logic          tx_valid;
  logic          tx_ready;
  logic [31:0]   tx_data;
  logic [3:0]    tx_keep;
  logic          tx_last;
  logic          done;
  logic          csum_ok;

  logic [31:0]   mem [0:1023];
  logic [3:0]    keep_tab [4] = '{4'hF, 4'h8, 4'hC, 4'hE};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  beat_t         beat_q [$];
  logic [AW-1:0] addr_q [$];
  logic          csum_q [$];
  int            done_cycs [$];
  int            reads_cnt = 0;
  int            pops_cnt = 0;
  int            beats_seen = 0;
  int            first_valid_cyc = -1;
  bit            ready_toggle = 1'b0;

  packet_tx #(.AW(AW), .HDR_BYTE(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .pkt_len   (pkt_len),
    .busy      (busy),
    .sram_ce   (sram_ce),
    .sram_addr (sram_addr),
    .sram_rdata(sram_rdata),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_keep   (tx_keep),
    .tx_last   (tx_last),
    .done      (done),
    .csum_ok   (csum_ok)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: one-cycle read latency
  always @(posedge clk) if (sram_ce) sram_rdata <= mem[sram_addr];

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = ready_toggle ? ~tx_ready : 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=present required=absent", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (tx_valid && tx_ready) begin
        pops_cnt++;
        beats_seen++;
        if (beat_q.size() == 0) begin
          fail("unexpected_beat");
        end else begin
          b = beat_q.pop_front();
          check("tx_data", tx_data, b.d);
          check("tx_keep", tx_keep, b.k);
          check("tx_last", tx_last, b.l);
        end
      end
      if (sram_ce) begin
        reads_cnt++;
        if (addr_q.size() == 0) fail("unexpected_read");
        else check("sram_addr", sram_addr, addr_q.pop_front());
        check("read_ahead_le2", 64'((reads_cnt - pops_cnt) <= 2), 1);
      end
      if (done) begin
        done_cycs.push_back(cyc);
        check("busy_at_done", busy, 1);
        if (csum_q.size() == 0) fail("unexpected_done");
        else check("csum_ok", csum_ok, csum_q.pop_front());
      end
    end
  end

  task automatic push_pkt(input int base, input int len, input logic exp_ok);
    int n;
    int a;
    beat_t b;
    n = (len + 3) / 4;
    for (int i = 0; i < n; i++) begin
      a   = (base + i) % 1024;
      b.d = mem[a];
      b.k = (i == n - 1) ? keep_tab[len % 4] : 4'hF;
      b.l = (i == n - 1);
      beat_q.push_back(b);
      addr_q.push_back(AW'(a));
    end
    csum_q.push_back(exp_ok);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_sram_ce"},   sram_ce,   0);
    check({tag, "_tx_valid"},  tx_valid,  0);
    check({tag, "_tx_last"},   tx_last,   0);
    check({tag, "_done"},      done,      0);
    check({tag, "_csum_ok"},   csum_ok,   0);
    check({tag, "_tx_keep"},   tx_keep,   0);
    check({tag, "_tx_data"},   tx_data,   0);
    check({tag, "_sram_addr"}, sram_addr, 0);
  endtask

  task automatic run_pkt(input int base, input int len, input logic exp_ok,
                         input bit toggle, input bit poke);
    int n;
    int t0;
    n = (len + 3) / 4;
    ready_toggle = toggle;
    done_cycs.delete();
    first_valid_cyc = -1;
    reads_cnt = 0;
    pops_cnt = 0;
    beats_seen = 0;
    push_pkt(base, len, exp_ok);
    start = 1'b1;
    base_addr = AW'(base);
    pkt_len = 16'(len);
    t0 = cyc;
    tick();
    start = 1'b0;
    if (poke) begin
      start = 1'b1;
      base_addr = AW'(100);
      pkt_len = 16'd4;
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < 400 && done_cycs.size() == 0; i++) tick();
    if (done_cycs.size() == 0) begin
      fail("done_timeout");
    end else if (!toggle) begin
      check("done_cycle", done_cycs[0], t0 + n + 3);
      if (n > 0) check("first_valid_cycle", first_valid_cyc, t0 + 3);
    end
    tick();
    tick();
    check("beats_left", beat_q.size(), 0);
    check("reads_left", addr_q.size(), 0);
    check("done_count", done_cycs.size(), 1);
    ready_toggle = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
    // Ethernet header then IPv4 header with checksum 0xB96B at word 6 [31:16]
    mem[0] = 32'h0011_2233;
    mem[1] = 32'h4455_0066;
    mem[2] = 32'h7788_99AA;
    mem[3] = 32'h0800_4500;
    mem[4] = 32'h002E_0000;
    mem[5] = 32'h4000_4011;
    mem[6] = 32'hB96B_C0A8;
    mem[7] = 32'h0001_C0A8;
    mem[8] = 32'h0002_1234;

    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    pkt_len = '0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // valid header, steady ready
    run_pkt(0, 60, 1'b1, 1'b0, 1'b0);
    // checksum field cleared
    mem[6] = 32'h0000_C0A8;
    run_pkt(0, 60, 1'b0, 1'b0, 1'b0);
    mem[6] = 32'hB96B_C0A8;
    // 61 bytes, toggling ready
    run_pkt(0, 61, 1'b1, 1'b1, 1'b0);
    // address wrap, with a start poked while busy
    run_pkt(1022, 16, 1'b0, 1'b0, 1'b1);
    // short packet never passes checksum
    run_pkt(0, 20, 1'b0, 1'b0, 1'b0);

    // zero length; start in FIN ignored; start right after done accepted
    done_cycs.delete();
    csum_q.push_back(1'b0);
    csum_q.push_back(1'b0);
    start = 1'b1;
    base_addr = '0;
    pkt_len = 16'd0;
    t0 = cyc;
    tick();
    base_addr = AW'(512);
    pkt_len = 16'd8;
    tick();
    base_addr = '0;
    pkt_len = 16'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("zero_len_done_count", done_cycs.size(), 2);
    if (done_cycs.size() >= 2) begin
      check("zero_len_done_cycle", done_cycs[0], t0 + 1);
      check("after_done_start_cycle", done_cycs[1], t0 + 3);
    end
    check("zero_len_csum_left", csum_q.size(), 0);

    // reset in the middle of a packet
    done_cycs.delete();
    beats_seen = 0;
    reads_cnt = 0;
    pops_cnt = 0;
    push_pkt(0, 60, 1'b1);
    start = 1'b1;
    base_addr = '0;
    pkt_len = 16'd60;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && beats_seen < 5; i++) tick();
    check("beats_before_rst", beats_seen, 5);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    beat_q.delete();
    addr_q.delete();
    csum_q.delete();
    tick();
    tick();
    #2;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("no_done_after_rst", done_cycs.size(), 0);

    // restart after reset streams from beat 0
    run_pkt(0, 60, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
